mux_sel_pipe: RTL and testbench

- Parametrised, registered N-input result selector for the datapath result stage.
- Generalises the fixed 64-bit 5-way result mux to any WIDTH and NUM_IN.
- Adds a valid/ready handshake with a 2-entry skid buffer, out-of-range select detection, per-beat N/Z flags, and a committed status-flag register.
- Sits between execute-unit results and the writeback/forwarding path.

---
 rtl/mux_sel_pipe.sv | 128 ++++++++++++
 tb/tb_mux_sel_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// Registered N-input result selector with a valid/ready handshake and a 2-entry skid buffer.
// Computes per-beat N/Z flags at accept and commits status flags when a flag-setting beat is handed off.

module mux_sel_lane #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] data,
    output logic             hit,
    output logic [WIDTH-1:0] gated
);
    assign hit   = (sel == SEL_W'(IDX));
    assign gated = hit ? data : '0;
endmodule

module mux_sel_pipe #(
    parameter  int WIDTH  = 64,
    parameter  int NUM_IN = 5,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_set_flags,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_neg,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    stat_n,
    output logic                    stat_z
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             sel_err;
        logic             set_flags;
    } beat_t;

    logic [NUM_IN-1:0][WIDTH-1:0] in_arr;
    logic [NUM_IN-1:0][WIDTH-1:0] lane_d;
    logic [NUM_IN-1:0]            lane_hit;
    logic [WIDTH-1:0]             sel_data;
    logic                         sel_hit;
    beat_t                        nb, m, s;
    logic                         m_vld, s_vld;
    logic                         accept, handoff;

    assign in_arr = in_data;

    // One-hot lanes: an out-of-range select hits no lane, so data falls to zero.
    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        mux_sel_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
            .sel   (in_sel),
            .data  (in_arr[k]),
            .hit   (lane_hit[k]),
            .gated (lane_d[k])
        );
    end

    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_data = sel_data | lane_d[k];
            sel_hit  = sel_hit | lane_hit[k];
        end
    end

    always_comb begin
        nb.data      = sel_data;
        nb.zero      = (sel_data == '0);
        nb.neg       = sel_data[WIDTH-1];
        nb.sel_err   = !sel_hit;
        nb.set_flags = in_set_flags;
    end

    assign in_ready = !s_vld && reset_n;
    assign accept   = in_valid && in_ready;
    assign handoff  = m_vld && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m      <= '0;
            s      <= '0;
            m_vld  <= 1'b0;
            s_vld  <= 1'b0;
            stat_n <= 1'b0;
            stat_z <= 1'b0;
        end else begin
            if (handoff && m.set_flags && !m.sel_err) begin
                stat_n <= m.neg;
                stat_z <= m.zero;
            end
            if (!m_vld || handoff) begin
                // Skid entry is older than anything arriving now; drain it first.
                if (s_vld) begin
                    m     <= s;
                    m_vld <= 1'b1;
                    s_vld <= 1'b0;
                end else if (accept) begin
                    m     <= nb;
                    m_vld <= 1'b1;
                end else begin
                    m_vld <= 1'b0;
                end
            end else if (accept) begin
                s     <= nb;
                s_vld <= 1'b1;
            end
        end
    end

    assign out_data    = m.data;
    assign out_zero    = m.zero;
    assign out_neg     = m.neg;
    assign out_sel_err = m.sel_err;
    assign out_valid   = m_vld;

    a_no_skid_without_main: assert property (@(posedge clk) disable iff (!reset_n) m_vld || !s_vld);
endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed and randomised checks of mux_sel_pipe: select table, backpressure,
// mid-transfer reset, scoreboarded streaming and an 8-bit/16-input sweep.

module tb_mux_sel_pipe;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [319:0] a_data;
    logic [2:0]   a_sel = '0;
    logic         a_sf = 1'b0, a_iv = 1'b0, a_ir, a_ov, a_or = 1'b0;
    logic [63:0]  a_od;
    logic         a_oz, a_on, a_oe, a_sn, a_sz;

    logic [127:0] b_data;
    logic [3:0]   b_sel = '0;
    logic         b_iv = 1'b0, b_ir, b_ov, b_or = 1'b0;
    logic [7:0]   b_od;
    logic         b_oz, b_on, b_oe, b_sn, b_sz;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_sel_pipe #(.WIDTH(64), .NUM_IN(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_sel(a_sel),
        .in_set_flags(a_sf), .in_valid(a_iv), .in_ready(a_ir),
        .out_data(a_od), .out_zero(a_oz), .out_neg(a_on), .out_sel_err(a_oe),
        .out_valid(a_ov), .out_ready(a_or), .stat_n(a_sn), .stat_z(a_sz)
    );

    mux_sel_pipe #(.WIDTH(8), .NUM_IN(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_data(b_data), .in_sel(b_sel),
        .in_set_flags(1'b0), .in_valid(b_iv), .in_ready(b_ir),
        .out_data(b_od), .out_zero(b_oz), .out_neg(b_on), .out_sel_err(b_oe),
        .out_valid(b_ov), .out_ready(b_or), .stat_n(b_sn), .stat_z(b_sz)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic        sf;
        logic [63:0] d;
        logic        z, n, e, sn, sz;
    } vec_t;

    typedef struct {
        logic [63:0] d;
        logic        z, n, e, sf;
    } beat_t;

    vec_t  vt[10];
    beat_t q[$];

    function automatic beat_t model(input logic [319:0] data, input logic [2:0] sel, input logic sf);
        beat_t b;
        if (sel < 3'd5) begin
            b.d = data[sel*64 +: 64];
            b.e = 1'b0;
        end else begin
            b.d = 64'h0;
            b.e = 1'b1;
        end
        b.z  = (b.d == 64'h0);
        b.n  = b.d[63];
        b.sf = sf;
        return b;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = 64'h0;
            1:       v = {1'b1, 31'($urandom), 32'($urandom)};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        logic        m_sn, m_sz, stalled;
        logic [63:0] last_d;
        logic        last_z, last_n, last_e;
        int          sent, got, cyc;
        beat_t       eb;

        a_data = {64'h5, 64'hFF, 64'h8000_0000_0000_0000, 64'h0, 64'h1};
        for (int k = 0; k < 16; k++) b_data[k*8 +: 8] = 8'(k);

        vt[0] = '{3'd2, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{3'd6, 1'b1, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[2] = '{3'd1, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{3'd1, 1'b1, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4] = '{3'd0, 1'b1, 64'h1,                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{3'd7, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6] = '{3'd3, 1'b1, 64'hFF,                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7] = '{3'd2, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8] = '{3'd2, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9] = '{3'd5, 1'b1, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset state
        #12;
        chkb("rst_out_valid", a_ov, 1'b0);
        chkb("rst_in_ready", a_ir, 1'b0);
        chk("rst_out_data", a_od, 64'h0);
        chkb("rst_stat_n", a_sn, 1'b0);
        chkb("rst_stat_z", a_sz, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chkb("rel_in_ready", a_ir, 1'b1);
        tick();

        // Select table, one beat then an idle cycle so the handoff commits flags
        a_or = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_sel = vt[i].sel; a_sf = vt[i].sf; a_iv = 1'b1;
            tick();
            chkb($sformatf("v%0d_valid", i), a_ov, 1'b1);
            chk($sformatf("v%0d_data", i), a_od, vt[i].d);
            chkb($sformatf("v%0d_zero", i), a_oz, vt[i].z);
            chkb($sformatf("v%0d_neg", i), a_on, vt[i].n);
            chkb($sformatf("v%0d_err", i), a_oe, vt[i].e);
            a_iv = 1'b0;
            tick();
            chkb($sformatf("v%0d_drained", i), a_ov, 1'b0);
            chkb($sformatf("v%0d_stat_n", i), a_sn, vt[i].sn);
            chkb($sformatf("v%0d_stat_z", i), a_sz, vt[i].sz);
        end

        // Backpressure: sel 0,3,4 with the sink stalled
        a_or = 1'b0; a_sf = 1'b0; a_iv = 1'b1; a_sel = 3'd0;
        tick();
        chkb("bp_ready1", a_ir, 1'b1);
        a_sel = 3'd3;
        tick();
        chkb("bp_ready2_full", a_ir, 1'b0);
        a_sel = 3'd4;
        tick();
        chkb("bp_ready3_held", a_ir, 1'b0);
        chk("bp_stable_data", a_od, 64'h1);
        a_or = 1'b1;
        tick();
        chk("bp_out1", a_od, 64'hFF);
        chkb("bp_ov1", a_ov, 1'b1);
        tick();
        a_iv = 1'b0;
        chk("bp_out2", a_od, 64'h5);
        chkb("bp_ov2", a_ov, 1'b1);
        tick();
        chkb("bp_empty", a_ov, 1'b0);
        chkb("bp_stat_hold", a_sn, 1'b1);

        // Reset while FULL
        a_or = 1'b0; a_iv = 1'b1; a_sel = 3'd3;
        tick();
        tick();
        chkb("mr_full", a_ir, 1'b0);
        a_iv = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chkb("mr_out_valid", a_ov, 1'b0);
        chkb("mr_in_ready", a_ir, 1'b0);
        chkb("mr_stat_n", a_sn, 1'b0);
        chkb("mr_stat_z", a_sz, 1'b0);
        chk("mr_out_data", a_od, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chkb("mr_rel_ready", a_ir, 1'b1);
        a_or = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chkb("mr_no_stale", a_ov, 1'b0);
        end

        // Random streaming against a queue model
        m_sn = 1'b0; m_sz = 1'b0; stalled = 1'b0;
        last_d = '0; last_z = 1'b0; last_n = 1'b0; last_e = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 5000) begin
            cyc++;
            a_or = ($urandom_range(0, 3) != 0);
            a_iv = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_sel = 3'($urandom_range(0, 7));
            a_sf = 1'($urandom_range(0, 1));
            for (int k = 0; k < 5; k++) a_data[k*64 +: 64] = rnd64();
            #1;
            if (a_iv && a_ir) begin
                q.push_back(model(a_data, a_sel, a_sf));
                sent++;
            end
            if (a_ov && a_or) begin
                if (q.size() == 0) begin
                    chkb("st_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    eb = q.pop_front();
                    checks++;
                    if (a_od !== eb.d || a_oz !== eb.z || a_on !== eb.n || a_oe !== eb.e) begin
                        failures++;
                        $display("FAIL st_beat%0d actual=%h/%b%b%b required=%h/%b%b%b",
                                 got, a_od, a_oz, a_on, a_oe, eb.d, eb.z, eb.n, eb.e);
                    end
                    if (eb.sf && !eb.e) begin
                        m_sn = eb.n;
                        m_sz = eb.z;
                    end
                end
                got++;
            end
            stalled = a_ov && !a_or;
            last_d = a_od; last_z = a_oz; last_n = a_on; last_e = a_oe;
            tick();
            chkb("st_stat_n", a_sn, m_sn);
            chkb("st_stat_z", a_sz, m_sz);
            if (stalled) begin
                checks++;
                if (!a_ov || a_od !== last_d || a_oz !== last_z || a_on !== last_n || a_oe !== last_e) begin
                    failures++;
                    $display("FAIL st_stable actual=%b/%h required=1/%h", a_ov, a_od, last_d);
                end
            end
        end
        chk("st_received", 64'(got), 64'd100);
        a_iv = 1'b0;

        // 8-bit, 16-input sweep, back to back
        b_or = 1'b1; b_iv = 1'b1;
        for (int k = 0; k < 16; k++) begin
            b_sel = 4'(k);
            tick();
            chk($sformatf("p%0d_data", k), 64'(b_od), 64'(k));
            chkb($sformatf("p%0d_zero", k), b_oz, (k == 0));
            chkb($sformatf("p%0d_err", k), b_oe, 1'b0);
        end
        b_iv = 1'b0;
        tick();
        chkb("p_drained", b_ov, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
